// File: rtl/int_to_fp_converter_if.sv
// Start/done handshake bundle between the codec sample path and the int-to-float converter.
interface int_to_fp_converter_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  clk_en;
  logic [DATA_WIDTH-1:0] dataa;
  logic [31:0]           result;
  logic                  done;
  logic                  busy;

  modport master (
    output clk_en, dataa,
    input  result, done, busy
  );

  modport slave (
    input  clk_en, dataa,
    output result, done, busy
  );
endinterface

// File: rtl/int_to_fp_converter.sv
// Iterative signed-sample to IEEE-754 single converter, scaled to [-1.0, +1.0).
// Normalisation shifts one bit per cycle, so the datapath needs no barrel shifter or priority encoder.
module int_to_fp_converter #(
  parameter int DATA_WIDTH = 24
) (
  input logic                  clock,
  input logic                  reset_n,
  int_to_fp_converter_if.slave bus
);

  if (DATA_WIDTH < 2 || DATA_WIDTH > 24) begin : g_bad_width
    $error("int_to_fp_converter: DATA_WIDTH must be within 2..24");
  end

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    PACK
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  sign;
  logic [DATA_WIDTH-1:0] mag;
  logic [7:0]            exp;
  logic                  zero_flag;
  logic [31:0]           result_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] abs_in;
  logic                  in_zero;
  logic [22:0]           frac;

  // The most negative input negates to itself, which read as unsigned is exactly 2^(W-1).
  always_comb begin
    abs_in  = bus.dataa[DATA_WIDTH-1] ? -bus.dataa : bus.dataa;
    in_zero = (bus.dataa == '0);
  end

  always_comb begin
    frac = 23'(mag[DATA_WIDTH-2:0]) << (24 - DATA_WIDTH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.clk_en) begin
          next_state = in_zero ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag[DATA_WIDTH-1]) begin
          next_state = PACK;
        end
      end
      PACK:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sign      <= 1'b0;
      mag       <= '0;
      exp       <= 8'd0;
      zero_flag <= 1'b0;
      result_q  <= 32'h0000_0000;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clk_en) begin
            sign      <= bus.dataa[DATA_WIDTH-1];
            mag       <= abs_in;
            exp       <= 8'd127;
            zero_flag <= in_zero;
          end
        end
        NORM: begin
          if (!mag[DATA_WIDTH-1]) begin
            mag <= mag << 1;
            exp <= exp - 8'd1;
          end
        end
        PACK: begin
          // The leading one is the implicit bit, so only the bits below it form the fraction.
          result_q <= zero_flag ? 32'h0000_0000 : {sign, exp, frac};
          done_q   <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Scoreboard bench for int_to_fp_converter: stimulus queues expected results and latencies,
// and a monitor checks them on every done pulse.
module tb_int_to_fp_converter;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          accept;
  } exp_t;

  logic clock;
  logic reset_n;
  int   cycle;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t mon_e;

  int_to_fp_converter_if #(.DATA_WIDTH(24)) bus ();

  int_to_fp_converter #(.DATA_WIDTH(24)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_output("result", bus.result, mon_e.res);
        check_output("latency", 32'(cycle - mon_e.accept), 32'(mon_e.lat));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic apply_stimulus(input logic [23:0] d, input logic [31:0] r, input int lat);
    wait_idle();
    bus.clk_en = 1'b1;
    bus.dataa  = d;
    sb_q.push_back('{r, lat, cycle + 1});
    @(negedge clock);
    bus.clk_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_output("drain_timeout", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total        = 0;
    bad          = 0;
    cycle        = 0;
    reset_n      = 1'b0;
    bus.clk_en   = 1'b0;
    bus.dataa    = '0;

    #2;
    check_output("reset_result", bus.result, 32'h0000_0000);
    check_output("reset_done", {31'd0, bus.done}, 32'd0);
    check_output("reset_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // +0.5 with busy observed on each in-flight cycle
    apply_stimulus(24'h400000, 32'h3F00_0000, 3);
    check_output("busy_c1", {31'd0, bus.busy}, 32'd1);
    @(negedge clock);
    check_output("busy_c2", {31'd0, bus.busy}, 32'd1);
    drain();

    apply_stimulus(24'h800000, 32'hBF80_0000, 2);
    drain();
    apply_stimulus(24'h7FFFFF, 32'h3F7F_FFFE, 3);
    drain();
    apply_stimulus(24'h000001, 32'h3400_0000, 25);
    drain();
    apply_stimulus(24'hFFFFFF, 32'hB400_0000, 25);
    drain();
    apply_stimulus(24'h000000, 32'h0000_0000, 1);
    drain();
    apply_stimulus(24'hC00000, 32'hBF00_0000, 3);
    drain();
    apply_stimulus(24'h200000, 32'h3E80_0000, 4);
    drain();

    // clk_en while busy must be ignored and must not disturb the held result
    apply_stimulus(24'h000001, 32'h3400_0000, 25);
    repeat (3) @(negedge clock);
    bus.clk_en = 1'b1;
    bus.dataa  = 24'h400000;
    @(negedge clock);
    bus.clk_en = 1'b0;
    check_output("busy_during_ignore", {31'd0, bus.busy}, 32'd1);
    check_output("result_hold_busy", bus.result, 32'h3E80_0000);
    drain();
    repeat (8) @(negedge clock);
    check_output("result_after_ignore", bus.result, 32'h3400_0000);

    // clk_en held across done: second conversion starts on the done cycle's edge
    begin
      int n;
      wait_idle();
      bus.clk_en = 1'b1;
      bus.dataa  = 24'h400000;
      sb_q.push_back('{32'h3F00_0000, 3, cycle + 1});
      @(negedge clock);
      bus.dataa = 24'h800000;
      n = 0;
      while (!bus.done && n < 50) begin
        @(negedge clock);
        n++;
      end
      check_output("b2b_done_seen", {31'd0, bus.done}, 32'd1);
      sb_q.push_back('{32'hBF80_0000, 2, cycle + 1});
      @(negedge clock);
      bus.clk_en = 1'b0;
      check_output("b2b_busy", {31'd0, bus.busy}, 32'd1);
      drain();
    end

    // asynchronous reset mid-normalisation
    wait_idle();
    bus.clk_en = 1'b1;
    bus.dataa  = 24'h000001;
    @(negedge clock);
    bus.clk_en = 1'b0;
    repeat (4) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_result", bus.result, 32'h0000_0000);
    check_output("async_rst_done", {31'd0, bus.done}, 32'd0);
    check_output("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check_output("post_rst_result", bus.result, 32'h0000_0000);
    apply_stimulus(24'h400000, 32'h3F00_0000, 3);
    drain();
    repeat (3) @(negedge clock);
    check_output("final_hold", bus.result, 32'h3F00_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
